// File: rtl/bus_scheduler_pkg.sv
// rtl/bus_scheduler_pkg.sv - shared state codes, size codes and IO-space decode for bus_scheduler
package bus_scheduler_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_INST   = 3'd1;
    localparam state_t ST_DRD    = 3'd2;
    localparam state_t ST_DWR    = 3'd3;
    localparam state_t ST_IOWAIT = 3'd4;
    localparam state_t ST_GAP    = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // IO space is selected by address bits [IO_LSB+1:IO_LSB] == IO_SPACE
    localparam logic [1:0] IO_SPACE = 2'b11;
    localparam int         IO_LSB   = 16;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/bus_scheduler.sv
// rtl/bus_scheduler.sv - arbitrates fetch and load/store requests onto a byte-wide RAM/IO bus
module bus_scheduler
    import bus_scheduler_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IO_GAP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_abort,
    output logic              inst_valid,
    output logic [31:0]       inst_data,
    input  logic              data_req,
    input  logic              data_rw,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_wdata,
    output logic              data_valid,
    output logic [31:0]       data_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_buffer_full
);

    localparam int CNT_W = 8;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        nb;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;
    logic [31:0]       buf_n;
    logic [CNT_W-1:0]  nb_w;
    logic [CNT_W-1:0]  nb_end;
    logic [1:0]        lane_rd;
    logic              rd_state;
    logic              capture;

    assign nb_w     = CNT_W'(nb);
    assign nb_end   = nb_w + 1'b1;
    assign lane_rd  = cnt[1:0] - 2'd1;
    assign rd_state = (state == ST_INST) || (state == ST_DRD);
    // ram_din carries the byte addressed one cycle earlier, so capture lags the address by one
    assign capture  = rd_state && rdy && (cnt != '0) && (cnt <= nb_w);

    always_comb begin
        buf_n = buf_q;
        buf_n[{lane_rd, 3'b000} +: 8] = ram_din;
        ram_wr     = 1'b0;
        ram_a      = '0;
        ram_dout   = '0;
        inst_valid = 1'b0;
        data_valid = 1'b0;
        case (state)
            ST_INST, ST_DRD: begin
                // while paused, re-address the last issued byte so its data is still on ram_din at resume
                if (rdy && cnt < nb_w)
                    ram_a = addr_q + ADDR_W'(cnt);
                else if (!rdy && cnt != '0 && cnt <= nb_w)
                    ram_a = addr_q + ADDR_W'(cnt - 1'b1);
                if (rdy && cnt == nb_end) begin
                    if (state == ST_DRD) data_valid = 1'b1;
                    else                 inst_valid = !inst_abort;
                end
            end
            ST_DWR, ST_IOWAIT: begin
                if (rdy && cnt < nb_w && !(state == ST_IOWAIT && io_buffer_full)) begin
                    ram_wr   = 1'b1;
                    ram_a    = addr_q + ADDR_W'(cnt);
                    ram_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
                end
                if (rdy && cnt == nb_w) data_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            nb         <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            inst_data  <= '0;
            data_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: if (rdy) begin
                    cnt   <= '0;
                    buf_q <= '0;
                    if (data_req) begin
                        addr_q  <= data_addr;
                        wdata_q <= data_wdata;
                        nb      <= size_bytes(data_size);
                        if (!data_rw)
                            state <= ST_DRD;
                        else if (data_addr[IO_LSB +: 2] == IO_SPACE)
                            state <= ST_IOWAIT;
                        else
                            state <= ST_DWR;
                    end else if (inst_req && !inst_abort) begin
                        addr_q <= inst_addr;
                        nb     <= 3'd4;
                        state  <= ST_INST;
                    end
                end
                ST_INST, ST_DRD: begin
                    if (state == ST_INST && inst_abort) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (rdy) begin
                        if (capture) buf_q <= buf_n;
                        if (capture && cnt == nb_w) begin
                            if (state == ST_INST) inst_data  <= buf_n;
                            else                  data_rdata <= buf_n;
                        end
                        if (cnt == nb_end) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DWR: if (rdy) begin
                    if (cnt == nb_w) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IOWAIT: if (rdy) begin
                    if (cnt == nb_w) begin
                        state <= (IO_GAP > 0) ? ST_GAP : ST_IDLE;
                        cnt   <= '0;
                    end else if (!io_buffer_full) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: if (rdy) begin
                    if (cnt >= CNT_W'(IO_GAP - 1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// tb/tb_bus_scheduler.sv - directed self-checking bench for bus_scheduler
module tb_bus_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_abort;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        data_req;
    logic        data_rw;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] mem [0:1023];
    logic       loaded = 1'b0;

    always #5 clk = ~clk;

    bus_scheduler #(.ADDR_W(32), .IO_GAP(2)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_abort(inst_abort),
        .inst_valid(inst_valid), .inst_data(inst_data),
        .data_req(data_req), .data_rw(data_rw), .data_addr(data_addr),
        .data_size(data_size), .data_wdata(data_wdata),
        .data_valid(data_valid), .data_rdata(data_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full)
    );

    // synchronous RAM: one cycle read latency, IO-space writes go to the UART, not memory
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'hEE;
            mem[10'h100] <= 8'h11; mem[10'h101] <= 8'h22; mem[10'h102] <= 8'h33; mem[10'h103] <= 8'h44;
            mem[10'h080] <= 8'h01; mem[10'h081] <= 8'h02; mem[10'h082] <= 8'h03; mem[10'h083] <= 8'h04;
            mem[10'h040] <= 8'hA0; mem[10'h041] <= 8'hB1; mem[10'h042] <= 8'hC2; mem[10'h043] <= 8'hD3;
            mem[10'h010] <= 8'h5A; mem[10'h011] <= 8'hA5;
            loaded <= 1'b1;
        end else if (ram_wr && ram_a[17:16] != 2'b11) begin
            mem[ram_a[9:0]] <= ram_dout;
        end
        ram_din <= mem[ram_a[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic dreq(input logic rw, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        data_req = 1'b1; data_rw = rw; data_addr = a; data_size = sz; data_wdata = wd;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; inst_req = 1'b0; inst_addr = '0; inst_abort = 1'b0;
        data_req = 1'b0; data_rw = 1'b0; data_addr = '0; data_size = '0; data_wdata = '0;
        io_buffer_full = 1'b0;

        // reset holds everything at zero even with a request pending
        repeat (3) tick();
        dreq(1'b0, 32'h100, 2'd2, 32'h0);
        settle();
        check("rst_ram_wr", 32'(ram_wr), 32'h0);
        check("rst_ram_a", ram_a, 32'h0);
        check("rst_ram_dout", 32'(ram_dout), 32'h0);
        check("rst_valids", {30'h0, inst_valid, data_valid}, 32'h0);
        check("rst_rdata", data_rdata, 32'h0);
        check("rst_idata", inst_data, 32'h0);

        // word load at 0x100: grant in the first cycle after reset release
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            check("wl_addr", ram_a, 32'h100 + 32'(k));
            check("wl_wr", 32'(ram_wr), 32'h0);
        end
        tick(); settle();
        check("wl_g5_valid", 32'(data_valid), 32'h0);
        tick(); settle();
        check("wl_g6_valid", 32'(data_valid), 32'h1);
        check("wl_rdata", data_rdata, 32'h44332211);
        data_req = 1'b0;
        tick(); settle();
        check("wl_pulse", 32'(data_valid), 32'h0);
        check("wl_hold", data_rdata, 32'h44332211);

        // data wins over a simultaneous fetch; fetch granted once data completes
        tick();
        dreq(1'b1, 32'h200, 2'd0, 32'h123456AB);
        inst_req = 1'b1; inst_addr = 32'h80;
        tick(); settle();
        check("pr_wr", 32'(ram_wr), 32'h1);
        check("pr_addr", ram_a, 32'h200);
        check("pr_dout", 32'(ram_dout), 32'hAB);
        tick(); settle();
        check("pr_dvalid", 32'(data_valid), 32'h1);
        check("pr_wr_off", 32'(ram_wr), 32'h0);
        data_req = 1'b0;
        tick(); settle();
        check("pr_idle_a", ram_a, 32'h0);
        tick(); settle();
        check("pr_inst_a", ram_a, 32'h80);
        repeat (4) tick();
        settle();
        check("pr_ivalid_early", 32'(inst_valid), 32'h0);
        tick(); settle();
        check("pr_ivalid", 32'(inst_valid), 32'h1);
        check("pr_idata", inst_data, 32'h04030201);
        inst_req = 1'b0;

        // IO byte store held off by a full UART buffer, then two gap cycles
        tick();
        dreq(1'b1, 32'h30000, 2'd0, 32'h00000041);
        io_buffer_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            check("io_wait_wr", 32'(ram_wr), 32'h0);
        end
        tick(); io_buffer_full = 1'b0; settle();
        check("io_wr", 32'(ram_wr), 32'h1);
        check("io_addr", ram_a, 32'h30000);
        check("io_dout", 32'(ram_dout), 32'h41);
        tick(); settle();
        check("io_dvalid", 32'(data_valid), 32'h1);
        data_req = 1'b0;
        tick();
        dreq(1'b1, 32'h300, 2'd0, 32'h0000005C);
        settle();
        check("io_gap1_wr", 32'(ram_wr), 32'h0);
        tick(); settle();
        check("io_gap2_wr", 32'(ram_wr), 32'h0);
        tick(); settle();
        check("io_regrant_wr", 32'(ram_wr), 32'h0);
        tick(); settle();
        check("io_next_wr", 32'(ram_wr), 32'h1);
        check("io_next_a", ram_a, 32'h300);
        tick(); settle();
        check("io_next_valid", 32'(data_valid), 32'h1);
        data_req = 1'b0;

        // fetch at 0x0 aborted at G+2, then a fetch at 0x40
        tick();
        inst_req = 1'b1; inst_addr = 32'h0;
        tick();
        tick(); inst_abort = 1'b1; settle();
        check("ab_running_a", ram_a, 32'h1);
        tick(); inst_abort = 1'b0; inst_addr = 32'h40; settle();
        check("ab_idle_a", ram_a, 32'h0);
        check("ab_no_valid", 32'(inst_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick(); settle();
            check("ab_quiet", 32'(inst_valid), 32'h0);
        end
        tick(); settle();
        check("ab_ivalid", 32'(inst_valid), 32'h1);
        check("ab_idata", inst_data, 32'hD3C2B1A0);
        inst_req = 1'b0;

        // half load at 0x10 with a two-cycle pause at G+2
        tick();
        dreq(1'b0, 32'h10, 2'd1, 32'h0);
        tick(); settle();
        check("hl_a0", ram_a, 32'h10);
        for (int k = 0; k < 2; k++) begin
            tick(); rdy = 1'b0; settle();
            check("hl_pause_wr", 32'(ram_wr), 32'h0);
            check("hl_pause_valid", 32'(data_valid), 32'h0);
        end
        tick(); rdy = 1'b1; settle();
        check("hl_a1", ram_a, 32'h11);
        tick(); settle();
        check("hl_g5_valid", 32'(data_valid), 32'h0);
        tick(); settle();
        check("hl_valid", 32'(data_valid), 32'h1);
        check("hl_rdata", data_rdata, 32'h0000A55A);
        data_req = 1'b0;

        // size code 3 behaves as a word
        tick();
        dreq(1'b0, 32'h80, 2'd3, 32'h0);
        repeat (5) tick();
        settle();
        check("s3_g5_valid", 32'(data_valid), 32'h0);
        tick(); settle();
        check("s3_valid", 32'(data_valid), 32'h1);
        check("s3_rdata", data_rdata, 32'h04030201);
        data_req = 1'b0;

        // reset at G+3 of a word store drops it; bus is usable right after release
        tick();
        dreq(1'b1, 32'h180, 2'd2, 32'hCAFEBABE);
        tick(); settle();
        check("rs_b0", {ram_a[23:0], ram_dout}, {24'h000180, 8'hBE});
        tick(); settle();
        check("rs_b1", {ram_a[23:0], ram_dout}, {24'h000181, 8'hBA});
        tick(); rst_n = 1'b0; data_req = 1'b0; settle();
        check("rs_wr_off", 32'(ram_wr), 32'h0);
        check("rs_valid_off", 32'(data_valid), 32'h0);
        tick(); rst_n = 1'b1;
        dreq(1'b0, 32'h181, 2'd0, 32'h0);
        settle();
        check("rs_after_valid", 32'(data_valid), 32'h0);
        tick(); settle();
        check("rs_reload_a", ram_a, 32'h181);
        tick(); settle();
        check("rs_g2_valid", 32'(data_valid), 32'h0);
        tick(); settle();
        check("rs_reload_valid", 32'(data_valid), 32'h1);
        check("rs_reload_data", data_rdata, 32'h000000BA);
        data_req = 1'b0;

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
